// File: rtl/tl_ctrl_pkg.sv
// rtl/tl_ctrl_pkg.sv - TileLink-UL control-port field widths and beat structs
package tl_ctrl_pkg;
  localparam int SRC_W  = 12;
  localparam int ADDR_W = 31;
  localparam int MASK_W = 8;
  localparam int SIZE_W = 2;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [2:0]        param;
    logic [SIZE_W-1:0] size;
    logic [SRC_W-1:0]  source;
    logic [ADDR_W-1:0] address;
    logic [MASK_W-1:0] mask;
    logic              corrupt;
  } tl_a_beat_t;

  typedef struct packed {
    logic [2:0]        opcode;
    logic [SIZE_W-1:0] size;
    logic [SRC_W-1:0]  source;
  } tl_d_beat_t;
endpackage

// File: rtl/tl_buffer_queue.sv
// rtl/tl_buffer_queue.sv - generic ready/valid FIFO; DEPTH=0 degenerates to wires
module tl_buffer_queue #(
  parameter int  DEPTH = 2,
  parameter bit  FLOW  = 1'b0,
  parameter bit  PIPE  = 1'b0,
  parameter type T     = logic [7:0]
) (
  input  logic clock,
  input  logic reset,
  input  logic enq_valid,
  output logic enq_ready,
  input  T     enq_bits,
  output logic deq_valid,
  input  logic deq_ready,
  output T     deq_bits
);

  if (DEPTH == 0) begin : g_wire
    assign deq_valid = enq_valid;
    assign deq_bits  = enq_bits;
    assign enq_ready = deq_ready;
  end else begin : g_fifo
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    T              mem_q [DEPTH];
    T              mem_d [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] enq_ptr_q, enq_ptr_d;
    logic [PW-1:0] deq_ptr_q, deq_ptr_d;
    logic          empty, full, enq_fire, deq_fire, bypass, do_enq, do_deq;

    always_comb begin
      empty     = (count_q == '0);
      full      = (count_q == FULL);
      enq_ready = !reset && (!full || (PIPE && deq_ready));
      deq_valid = !reset && (!empty || (FLOW && enq_valid));
      deq_bits  = (FLOW && empty) ? enq_bits : mem_q[deq_ptr_q];
      enq_fire  = enq_valid && enq_ready;
      deq_fire  = deq_valid && deq_ready;
      // A flow-through beat that leaves immediately never touches the store.
      bypass    = FLOW && empty && deq_fire;
      do_enq    = enq_fire && !bypass;
      do_deq    = deq_fire && !bypass;

      mem_d     = mem_q;
      enq_ptr_d = enq_ptr_q;
      deq_ptr_d = deq_ptr_q;
      count_d   = count_q;
      if (do_enq) begin
        mem_d[enq_ptr_q] = enq_bits;
        enq_ptr_d = (enq_ptr_q == LAST) ? '0 : enq_ptr_q + 1'b1;
      end
      if (do_deq) begin
        deq_ptr_d = (deq_ptr_q == LAST) ? '0 : deq_ptr_q + 1'b1;
      end
      if (do_enq && !do_deq) begin
        count_d = count_q + 1'b1;
      end else if (!do_enq && do_deq) begin
        count_d = count_q - 1'b1;
      end
    end

    always_ff @(posedge clock) begin
      if (reset) begin
        count_q   <= '0;
        enq_ptr_q <= '0;
        deq_ptr_q <= '0;
      end else begin
        count_q   <= count_d;
        enq_ptr_q <= enq_ptr_d;
        deq_ptr_q <= deq_ptr_d;
      end
      mem_q <= mem_d;
    end

    a_no_enq_full:  assert property (@(posedge clock) disable iff (reset) !(do_enq && full && !do_deq));
    a_no_deq_empty: assert property (@(posedge clock) disable iff (reset) !(do_deq && empty));
    a_count_range:  assert property (@(posedge clock) disable iff (reset) count_q <= FULL);
  end

endmodule

// File: rtl/tl_control_xing_buffer.sv
// rtl/tl_control_xing_buffer.sv - TileLink-UL A/D buffer between fragmenter and control-bus crossing
module tl_control_xing_buffer
  import tl_ctrl_pkg::*;
#(
  parameter int A_DEPTH = 2,
  parameter int D_DEPTH = 2,
  parameter bit FLOW    = 1'b0,
  parameter bit PIPE    = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              in_a_valid,
  output logic              in_a_ready,
  input  logic [2:0]        in_a_bits_opcode,
  input  logic [2:0]        in_a_bits_param,
  input  logic [SIZE_W-1:0] in_a_bits_size,
  input  logic [SRC_W-1:0]  in_a_bits_source,
  input  logic [ADDR_W-1:0] in_a_bits_address,
  input  logic [MASK_W-1:0] in_a_bits_mask,
  input  logic              in_a_bits_corrupt,
  output logic              out_a_valid,
  input  logic              out_a_ready,
  output logic [2:0]        out_a_bits_opcode,
  output logic [2:0]        out_a_bits_param,
  output logic [SIZE_W-1:0] out_a_bits_size,
  output logic [SRC_W-1:0]  out_a_bits_source,
  output logic [ADDR_W-1:0] out_a_bits_address,
  output logic [MASK_W-1:0] out_a_bits_mask,
  output logic              out_a_bits_corrupt,
  input  logic              out_d_valid,
  output logic              out_d_ready,
  input  logic [2:0]        out_d_bits_opcode,
  input  logic [SIZE_W-1:0] out_d_bits_size,
  input  logic [SRC_W-1:0]  out_d_bits_source,
  output logic              in_d_valid,
  input  logic              in_d_ready,
  output logic [2:0]        in_d_bits_opcode,
  output logic [SIZE_W-1:0] in_d_bits_size,
  output logic [SRC_W-1:0]  in_d_bits_source
);

  tl_a_beat_t a_enq, a_deq;
  tl_d_beat_t d_enq, d_deq;

  assign a_enq = {in_a_bits_opcode, in_a_bits_param, in_a_bits_size, in_a_bits_source,
                  in_a_bits_address, in_a_bits_mask, in_a_bits_corrupt};
  assign {out_a_bits_opcode, out_a_bits_param, out_a_bits_size, out_a_bits_source,
          out_a_bits_address, out_a_bits_mask, out_a_bits_corrupt} = a_deq;
  assign d_enq = {out_d_bits_opcode, out_d_bits_size, out_d_bits_source};
  assign {in_d_bits_opcode, in_d_bits_size, in_d_bits_source} = d_deq;

  tl_buffer_queue #(.DEPTH(A_DEPTH), .FLOW(FLOW), .PIPE(PIPE), .T(tl_a_beat_t)) u_a_queue (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (in_a_valid),
    .enq_ready (in_a_ready),
    .enq_bits  (a_enq),
    .deq_valid (out_a_valid),
    .deq_ready (out_a_ready),
    .deq_bits  (a_deq)
  );

  tl_buffer_queue #(.DEPTH(D_DEPTH), .FLOW(FLOW), .PIPE(PIPE), .T(tl_d_beat_t)) u_d_queue (
    .clock     (clock),
    .reset     (reset),
    .enq_valid (out_d_valid),
    .enq_ready (out_d_ready),
    .enq_bits  (d_enq),
    .deq_valid (in_d_valid),
    .deq_ready (in_d_ready),
    .deq_bits  (d_deq)
  );

endmodule

// File: tb/tb_tl_control_xing_buffer.sv
// tb/tb_tl_control_xing_buffer.sv - directed bench over default, FLOW/PIPE/D_DEPTH=3 and DEPTH=0 builds
module tb_tl_control_xing_buffer;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        ia_v = 1'b0;
  logic [59:0] ia   = '0;
  logic        oa_r = 1'b0;
  logic        od_v = 1'b0;
  logic [16:0] od   = '0;
  logic        id_r = 1'b0;

  wire [2:0]  ia_r, oa_v, od_r, id_v;
  wire [59:0] oa [3];
  wire [16:0] id [3];

  int checks = 0;
  int failures = 0;
  logic [59:0] sa [$];
  logic [16:0] sd [$];

  // 0: defaults, 1: FLOW=PIPE=1 with D_DEPTH=3, 2: both channels DEPTH=0
  for (genvar k = 0; k < 3; k++) begin : g_dut
    tl_control_xing_buffer #(
      .A_DEPTH(k == 2 ? 0 : 2),
      .D_DEPTH(k == 0 ? 2 : (k == 1 ? 3 : 0)),
      .FLOW   (k == 1),
      .PIPE   (k == 1)
    ) u_dut (
      .clock              (clk),
      .reset              (rst),
      .in_a_valid         (ia_v),
      .in_a_ready         (ia_r[k]),
      .in_a_bits_opcode   (ia[59:57]),
      .in_a_bits_param    (ia[56:54]),
      .in_a_bits_size     (ia[53:52]),
      .in_a_bits_source   (ia[51:40]),
      .in_a_bits_address  (ia[39:9]),
      .in_a_bits_mask     (ia[8:1]),
      .in_a_bits_corrupt  (ia[0]),
      .out_a_valid        (oa_v[k]),
      .out_a_ready        (oa_r),
      .out_a_bits_opcode  (oa[k][59:57]),
      .out_a_bits_param   (oa[k][56:54]),
      .out_a_bits_size    (oa[k][53:52]),
      .out_a_bits_source  (oa[k][51:40]),
      .out_a_bits_address (oa[k][39:9]),
      .out_a_bits_mask    (oa[k][8:1]),
      .out_a_bits_corrupt (oa[k][0]),
      .out_d_valid        (od_v),
      .out_d_ready        (od_r[k]),
      .out_d_bits_opcode  (od[16:14]),
      .out_d_bits_size    (od[13:12]),
      .out_d_bits_source  (od[11:0]),
      .in_d_valid         (id_v[k]),
      .in_d_ready         (id_r),
      .in_d_bits_opcode   (id[k][16:14]),
      .in_d_bits_size     (id[k][13:12]),
      .in_d_bits_source   (id[k][11:0])
    );
  end

  function automatic logic [59:0] mk_a(input logic [2:0] op, input logic [2:0] prm,
                                       input logic [11:0] src, input logic [30:0] adr,
                                       input logic [7:0] msk, input logic cor);
    return {op, prm, 2'd2, src, adr, msk, cor};
  endfunction

  function automatic logic [16:0] mk_d(input logic [2:0] op, input logic [1:0] sz,
                                       input logic [11:0] src);
    return {op, sz, src};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [59:0] b1, b2, b3, s, p1, p2, p3, q1, q2;
  logic [16:0] r1, dd;

  initial begin
    // Reset: everything quiet while high, readies up once released
    tick(); tick();
    #1;
    chk("rst_ia_ready", ia_r[0], 1'b0);
    chk("rst_oa_valid", oa_v[0], 1'b0);
    chk("rst_od_ready", od_r[0], 1'b0);
    chk("rst_id_valid", id_v[0], 1'b0);
    chk("rst_ia_ready_u1", ia_r[1], 1'b0);
    rst = 1'b0;
    #1;
    chk("post_rst_ia_ready", ia_r[0], 1'b1);
    chk("post_rst_od_ready", od_r[0], 1'b1);

    // Single Get beat
    b1 = mk_a(3'd4, 3'd0, 12'h0A5, 31'h0200_0000, 8'hFF, 1'b0);
    ia = b1; ia_v = 1'b1;
    #1;
    chk("t1_no_same_cycle", oa_v[0], 1'b0);
    chk("t1_flow_valid", oa_v[1], 1'b1);
    chk("t1_flow_bits", oa[1], b1);
    chk("t1_wire_valid", oa_v[2], 1'b1);
    chk("t1_wire_bits", oa[2], b1);
    chk("t1_wire_ready", ia_r[2], 1'b0);
    tick();
    ia_v = 1'b0;
    #1;
    chk("t1_valid_next", oa_v[0], 1'b1);
    chk("t1_bits_next", oa[0], b1);
    chk("t1_ready_kept", ia_r[0], 1'b1);
    oa_r = 1'b1;
    tick();
    chk("t1_drained", oa_v[0], 1'b0);
    oa_r = 1'b0;

    // Backpressure: two accepted, third stalls until space frees
    b1 = mk_a(3'd1, 3'd1, 12'h101, 31'h0000_0100, 8'h0F, 1'b0);
    b2 = mk_a(3'd0, 3'd2, 12'h202, 31'h7FFF_FFFF, 8'hF0, 1'b1);
    b3 = mk_a(3'd4, 3'd0, 12'hFFF, 31'h1234_5678, 8'h3C, 1'b0);
    ia_v = 1'b1; ia = b1;
    tick();
    ia = b2;
    tick();
    ia = b3;
    #1;
    chk("t2_full_ready", ia_r[0], 1'b0);
    tick();
    chk("t2_full_hold", ia_r[0], 1'b0);
    chk("t2_head_stable", oa[0], b1);
    oa_r = 1'b1;
    #1;
    chk("t2_nopipe_ready", ia_r[0], 1'b0);
    chk("t2_first", oa[0], b1);
    tick();
    chk("t2_ready_back", ia_r[0], 1'b1);
    chk("t2_second", oa[0], b2);
    tick();
    ia_v = 1'b0;
    #1;
    chk("t2_third", oa[0], b3);
    tick();
    chk("t2_empty", oa_v[0], 1'b0);
    oa_r = 1'b0;

    // Steady state at count=1 with simultaneous enq/deq
    s = mk_a(3'd4, 3'd0, 12'h5A5, 31'h0000_0040, 8'hFF, 1'b0);
    ia = s; ia_v = 1'b1;
    sa.push_back(s);
    tick();
    oa_r = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s = mk_a(3'd4, 3'd0, 12'($urandom), 31'(i * 8), 8'hFF, 1'b0);
      ia = s;
      sa.push_back(s);
      #1;
      chk("t3_order", oa[0], sa[0]);
      chk("t3_ready", ia_r[0], 1'b1);
      tick();
      void'(sa.pop_front());
    end
    ia_v = 1'b0;
    #1;
    chk("t3_last_valid", oa_v[0], 1'b1);
    chk("t3_last", oa[0], sa[0]);
    tick();
    void'(sa.pop_front());
    chk("t3_empty", oa_v[0], 1'b0);
    oa_r = 1'b0;

    rst = 1'b1;
    tick();
    rst = 1'b0;

    // PIPE: full queue accepts while dequeuing
    p1 = mk_a(3'd0, 3'd0, 12'h011, 31'h0000_1000, 8'h01, 1'b0);
    p2 = mk_a(3'd1, 3'd0, 12'h022, 31'h0000_2000, 8'h02, 1'b0);
    p3 = mk_a(3'd4, 3'd0, 12'h033, 31'h0000_3000, 8'h04, 1'b0);
    ia_v = 1'b1; ia = p1;
    tick();
    ia = p2;
    tick();
    ia = p3;
    #1;
    chk("t4_full_no_deq", ia_r[1], 1'b0);
    oa_r = 1'b1;
    #1;
    chk("t4_pipe_ready", ia_r[1], 1'b1);
    chk("t4_nopipe_ready", ia_r[0], 1'b0);
    chk("t4_head", oa[1], p1);
    tick();
    ia_v = 1'b0; oa_r = 1'b0;
    #1;
    chk("t4_still_full", ia_r[1], 1'b0);
    chk("t4_next", oa[1], p2);
    oa_r = 1'b1;
    tick();
    chk("t4_pipelined", oa[1], p3);
    tick();
    chk("t4_empty", oa_v[1], 1'b0);
    oa_r = 1'b0;

    // FLOW on an empty D queue
    dd = mk_d(3'd1, 2'd2, 12'h7FF);
    od = dd; od_v = 1'b1; id_r = 1'b1;
    #1;
    chk("t4_flow_d_valid", id_v[1], 1'b1);
    chk("t4_flow_d_bits", id[1], dd);
    chk("t4_noflow_d_valid", id_v[0], 1'b0);
    chk("t4_wire_d_bits", id[2], dd);
    chk("t4_wire_d_ready", od_r[2], 1'b1);
    tick();
    od_v = 1'b0;
    #1;
    chk("t4_flow_not_stored", id_v[1], 1'b0);
    chk("t4_noflow_d_bits", id[0], dd);
    tick();
    id_r = 1'b0;

    // Reset with entries held
    q1 = mk_a(3'd4, 3'd0, 12'hAAA, 31'h0000_0008, 8'hFF, 1'b0);
    q2 = mk_a(3'd4, 3'd0, 12'hBBB, 31'h0000_0010, 8'hFF, 1'b0);
    r1 = mk_d(3'd1, 2'd3, 12'hCCC);
    ia_v = 1'b1; ia = q1;
    tick();
    ia = q2;
    tick();
    ia_v = 1'b0; od_v = 1'b1; od = r1;
    tick();
    od_v = 1'b0;
    #1;
    chk("t5_a_held", oa_v[0], 1'b1);
    chk("t5_d_held", id_v[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("t5_rst_oa_valid", oa_v[0], 1'b0);
    chk("t5_rst_id_valid", id_v[0], 1'b0);
    chk("t5_rst_ia_ready", ia_r[0], 1'b0);
    chk("t5_rst_od_ready", od_r[0], 1'b0);
    tick();
    rst = 1'b0; oa_r = 1'b1; id_r = 1'b1;
    #1;
    chk("t5_oa_valid", oa_v[0], 1'b0);
    chk("t5_id_valid", id_v[0], 1'b0);
    chk("t5_ia_ready", ia_r[0], 1'b1);
    chk("t5_od_ready", od_r[0], 1'b1);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t5_no_stale", {oa_v[0], id_v[0], oa_v[1], id_v[1]}, 4'b0000);
    end
    oa_r = 1'b0; id_r = 1'b0;

    // D_DEPTH=3: one full fill then 2-in/2-out rounds so pointers wrap off-phase
    for (int r = 0; r < 5; r++) begin
      for (int j = 0; j < ((r == 0) ? 3 : 2); j++) begin
        dd = mk_d(3'(r), 2'(j), 12'(16 * r + j + 1));
        od = dd; od_v = 1'b1;
        sd.push_back(dd);
        #1;
        chk("t6_fill_ready", od_r[1], 1'b1);
        tick();
      end
      od_v = 1'b0;
      #1;
      if (r == 0) chk("t6_full_ready", od_r[1], 1'b0);
      id_r = 1'b1;
      while (sd.size() != 0) begin
        #1;
        chk("t6_drain_valid", id_v[1], 1'b1);
        chk("t6_drain_order", id[1], sd[0]);
        tick();
        void'(sd.pop_front());
      end
      id_r = 1'b0;
      #1;
      chk("t6_drained", id_v[1], 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
